// File: rtl/keypad_code_entry_if.sv
// rtl/keypad_code_entry_if.sv - keypad key stream and PIN submission bundle
// master drives keys; slave (the collector) returns the submitted code and status.
interface keypad_code_entry_if #(
    parameter int NUM_DIGITS = 4
);
    logic                              key_valid;
    logic [3:0]                        key_value;
    logic [4*NUM_DIGITS-1:0]           code;
    logic                              code_ack;
    logic                              entry_active;
    logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count;
    logic                              key_reject;

    modport master (
        output key_valid, key_value,
        input  code, code_ack, entry_active, digit_count, key_reject
    );

    modport slave (
        input  key_valid, key_value,
        output code, code_ack, entry_active, digit_count, key_reject
    );
endinterface

// File: rtl/keypad_code_entry.sv
// rtl/keypad_code_entry.sv - collects BCD keypad digits into a PIN and strobes it downstream
// Optional macro KEY_EDGE_DETECT_EN: accept a key only on a rising edge of key_valid.
module keypad_code_entry #(
    parameter int NUM_DIGITS     = 4,
    parameter int ACK_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vehicle_arrival,
    input  logic               vehicle_left,
    keypad_code_entry_if.slave bus
);
    localparam int CODE_W = 4 * NUM_DIGITS;
    localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int ACK_W  = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] FULL     = CNT_W'(NUM_DIGITS);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, ACK} state_t;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   buffer_q, buffer_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ACK_W-1:0]    ack_q, ack_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                reject_q, reject_d;
    logic                key_press;
    logic                abort;

`ifdef KEY_EDGE_DETECT_EN
    logic key_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) key_valid_q <= 1'b0;
        else      key_valid_q <= bus.key_valid;
    end

    assign key_press = bus.key_valid & ~key_valid_q;
`else
    assign key_press = bus.key_valid;
`endif

    assign abort = vehicle_left | ~vehicle_arrival;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            buffer_q <= '0;
            code_q   <= '0;
            count_q  <= '0;
            ack_q    <= '0;
            timer_q  <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            buffer_q <= buffer_d;
            code_q   <= code_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            timer_q  <= timer_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        buffer_d = buffer_q;
        code_d   = code_q;
        count_d  = count_q;
        ack_d    = '0;
        timer_d  = '0;
        reject_d = 1'b0;
        if (abort) begin
            state_d  = IDLE;
            buffer_d = '0;
            code_d   = '0;
            count_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = COLLECT;
                    buffer_d = '0;
                    count_d  = '0;
                end
                COLLECT: begin
                    if (key_press) begin
                        if (bus.key_value <= 4'd9) begin
                            if (count_q < FULL) begin
                                buffer_d = (buffer_q << 4) | CODE_W'(bus.key_value);
                                count_d  = count_q + 1'b1;
                            end else begin
                                reject_d = 1'b1;
                            end
                        end else if (bus.key_value == 4'hA) begin
                            buffer_d = '0;
                            count_d  = '0;
                        end else if (bus.key_value == 4'hB) begin
                            buffer_d = '0;
                            count_d  = '0;
                            if (count_q == FULL) begin
                                code_d  = buffer_q;
                                state_d = ACK;
                            end else begin
                                reject_d = 1'b1;
                            end
                        end else begin
                            reject_d = 1'b1;
                        end
                    end else if (!bus.key_valid && count_q != '0) begin
                        // A held key (edge-detect build) keeps the timer reloaded.
                        if (timer_q == TMR_LAST) begin
                            buffer_d = '0;
                            count_d  = '0;
                            reject_d = 1'b1;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end
                ACK: begin
                    reject_d = key_press;
                    if (ack_q == ACK_LAST) state_d = COLLECT;
                    else                   ack_d   = ack_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.code         = code_q;
    assign bus.code_ack     = (state_q == ACK);
    assign bus.entry_active = (state_q != IDLE);
    assign bus.digit_count  = count_q;
    assign bus.key_reject   = reject_q;
endmodule

// File: tb/tb_keypad_code_entry.sv
// tb/tb_keypad_code_entry.sv - directed and randomized checks of keypad_code_entry
// Build with KEY_EDGE_DETECT_EN to check the edge-detect variant.
module tb_keypad_code_entry;
    localparam int ND  = 4;
    localparam int ACK = 4;
    localparam int TMO = 12;
    localparam int CW  = 4 * ND;
`ifdef KEY_EDGE_DETECT_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic vehicle_arrival = 1'b0;
    logic vehicle_left = 1'b0;
    int   errors = 0;
    int   checks = 0;

    keypad_code_entry_if #(.NUM_DIGITS(ND)) bus ();

    keypad_code_entry #(.NUM_DIGITS(ND), .ACK_CYCLES(ACK), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .vehicle_arrival(vehicle_arrival),
        .vehicle_left(vehicle_left), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: digits kept as a queue, submission as an integer value.
    int m_q[$];
    bit m_active;
    int m_ack_left;
    int m_code;
    int m_idle;
    bit m_prev_kv;
    bit m_reject;

    task automatic model_step(input bit va, input bit vl, input bit kv, input int kval);
        bit press;
        press = kv && !(EDGE && m_prev_kv);
        m_prev_kv = kv;
        m_reject = 1'b0;
        if (vl || !va) begin
            m_active = 0; m_ack_left = 0; m_q.delete(); m_code = 0; m_idle = 0;
        end else if (!m_active) begin
            m_active = 1; m_q.delete(); m_idle = 0;
        end else if (m_ack_left > 0) begin
            m_reject = press;
            m_ack_left--;
            m_idle = 0;
        end else begin
            if (press) begin
                if (kval < 10) begin
                    if (m_q.size() < ND) m_q.push_back(kval);
                    else m_reject = 1'b1;
                end else if (kval == 10) begin
                    m_q.delete();
                end else if (kval == 11) begin
                    if (m_q.size() == ND) begin
                        m_code = 0;
                        foreach (m_q[i]) m_code = m_code * 16 + m_q[i];
                        m_ack_left = ACK;
                    end else begin
                        m_reject = 1'b1;
                    end
                    m_q.delete();
                end else begin
                    m_reject = 1'b1;
                end
            end
            if (kv) m_idle = 0;
            else if (m_q.size() > 0) begin
                m_idle++;
                if (m_idle == TMO) begin m_q.delete(); m_reject = 1'b1; m_idle = 0; end
            end else m_idle = 0;
        end
    endtask

    task automatic step(input logic kv, input logic [3:0] kval);
        bus.key_valid = kv;
        bus.key_value = kval;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.key_valid = 1'b0; bus.key_value = 4'h0;
        vehicle_arrival = 1'b0; vehicle_left = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        m_q.delete(); m_active = 0; m_ack_left = 0; m_code = 0; m_idle = 0; m_prev_kv = 0; m_reject = 0;
    endtask

    task automatic test_reset();
        int keys[5] = '{1, 2, 3, 4, 11};
        do_reset();
        checks++; if (bus.code !== '0) begin errors++; $display("FAIL reset_code: got %h want 0", bus.code); end
        checks++; if (bus.entry_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", bus.entry_active); end
        vehicle_arrival = 1'b1;
        step(1'b0, 4'h0);
        foreach (keys[i]) step(1'b1, 4'(keys[i]));
        repeat (ACK) step(1'b0, 4'h0);
        step(1'b1, 4'h1);
        step(1'b1, 4'h2);
        checks++; if (bus.digit_count !== 3'd2) begin errors++; $display("FAIL rst_pre_count: got %0d want 2", bus.digit_count); end
        checks++; if (bus.code !== 16'h1234) begin errors++; $display("FAIL rst_pre_code: got %h want 1234", bus.code); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.code !== '0) begin errors++; $display("FAIL async_code: got %h want 0", bus.code); end
        checks++; if (bus.digit_count !== '0) begin errors++; $display("FAIL async_count: got %0d want 0", bus.digit_count); end
        checks++; if (bus.entry_active !== 1'b0) begin errors++; $display("FAIL async_active: got %b want 0", bus.entry_active); end
        checks++; if (bus.code_ack !== 1'b0 || bus.key_reject !== 1'b0) begin errors++; $display("FAIL async_ack_rej: got %b%b want 00", bus.code_ack, bus.key_reject); end
        #1 rst = 1'b1;
    endtask

    task automatic test_normal_entry();
        int  keys[4] = '{5, 9, 9, 0};
        logic rej = 1'b0;
        do_reset();
        vehicle_arrival = 1'b1;
        step(1'b0, 4'h0);
        foreach (keys[i]) begin step(1'b1, 4'(keys[i])); rej |= bus.key_reject; end
        step(1'b1, 4'hB);
        rej |= bus.key_reject;
        checks++; if (bus.code !== 16'h5990) begin errors++; $display("FAIL normal_code: got %h want 5990", bus.code); end
        checks++; if (bus.code_ack !== 1'b1) begin errors++; $display("FAIL normal_ack0: got %b want 1", bus.code_ack); end
        checks++; if (bus.digit_count !== '0) begin errors++; $display("FAIL normal_count: got %0d want 0", bus.digit_count); end
        for (int i = 1; i < ACK; i++) begin
            step(1'b0, 4'h0);
            rej |= bus.key_reject;
            checks++; if (bus.code_ack !== 1'b1 || bus.code !== 16'h5990) begin errors++; $display("FAIL normal_ack_hold%0d: got %b/%h want 1/5990", i, bus.code_ack, bus.code); end
        end
        step(1'b0, 4'h0);
        checks++; if (bus.code_ack !== 1'b0) begin errors++; $display("FAIL normal_ack_end: got %b want 0", bus.code_ack); end
        checks++; if (bus.code !== 16'h5990 || bus.entry_active !== 1'b1) begin errors++; $display("FAIL normal_after: got %h/%b want 5990/1", bus.code, bus.entry_active); end
        checks++; if (rej !== 1'b0) begin errors++; $display("FAIL normal_noreject: got %b want 0", rej); end
    endtask

    task automatic test_short_invalid();
        do_reset();
        vehicle_arrival = 1'b1;
        step(1'b0, 4'h0);
        step(1'b1, 4'h1);
        step(1'b1, 4'h2);
        step(1'b1, 4'hB);
        checks++; if (bus.key_reject !== 1'b1) begin errors++; $display("FAIL short_reject: got %b want 1", bus.key_reject); end
        checks++; if (bus.code !== '0 || bus.code_ack !== 1'b0 || bus.digit_count !== '0) begin errors++; $display("FAIL short_state: got %h/%b/%0d want 0/0/0", bus.code, bus.code_ack, bus.digit_count); end
        step(1'b1, 4'h7);
        step(1'b1, 4'hE);
        checks++; if (bus.key_reject !== 1'b1 || bus.digit_count !== 3'd1) begin errors++; $display("FAIL invalid_key: got rej %b cnt %0d want 1/1", bus.key_reject, bus.digit_count); end
        step(1'b1, 4'hA);
        checks++; if (bus.key_reject !== 1'b0 || bus.digit_count !== '0) begin errors++; $display("FAIL clear_key: got rej %b cnt %0d want 0/0", bus.key_reject, bus.digit_count); end
        for (int d = 1; d <= 4; d++) step(1'b1, 4'(d));
        step(1'b1, 4'h5);
        checks++; if (bus.key_reject !== 1'b1 || bus.digit_count !== 3'd4) begin errors++; $display("FAIL overflow: got rej %b cnt %0d want 1/4", bus.key_reject, bus.digit_count); end
        step(1'b1, 4'hB);
        checks++; if (bus.code !== 16'h1234 || bus.code_ack !== 1'b1) begin errors++; $display("FAIL overflow_code: got %h/%b want 1234/1", bus.code, bus.code_ack); end
    endtask

    task automatic test_clear_timeout();
        logic rej = 1'b0;
        int   keys[5] = '{4, 3, 2, 1, 11};
        do_reset();
        vehicle_arrival = 1'b1;
        step(1'b0, 4'h0);
        step(1'b1, 4'h3); step(1'b1, 4'h1); step(1'b1, 4'hA);
        checks++; if (bus.digit_count !== '0 || bus.key_reject !== 1'b0) begin errors++; $display("FAIL clear_count: got %0d/%b want 0/0", bus.digit_count, bus.key_reject); end
        step(1'b1, 4'h3); step(1'b1, 4'h1);
        repeat (TMO - 1) begin step(1'b0, 4'h0); rej |= bus.key_reject; end
        checks++; if (rej !== 1'b0 || bus.digit_count !== 3'd2) begin errors++; $display("FAIL timeout_early: got rej %b cnt %0d want 0/2", rej, bus.digit_count); end
        step(1'b0, 4'h0);
        checks++; if (bus.key_reject !== 1'b1 || bus.digit_count !== '0) begin errors++; $display("FAIL timeout_fire: got rej %b cnt %0d want 1/0", bus.key_reject, bus.digit_count); end
        step(1'b0, 4'h0);
        checks++; if (bus.key_reject !== 1'b0) begin errors++; $display("FAIL timeout_single: got %b want 0", bus.key_reject); end
        foreach (keys[i]) step(1'b1, 4'(keys[i]));
        checks++; if (bus.code !== 16'h4321 || bus.code_ack !== 1'b1) begin errors++; $display("FAIL timeout_code: got %h/%b want 4321/1", bus.code, bus.code_ack); end
    endtask

    task automatic test_abort();
        int keys[5] = '{8, 6, 4, 2, 11};
        do_reset();
        vehicle_arrival = 1'b1;
        step(1'b0, 4'h0);
        foreach (keys[i]) step(1'b1, 4'(keys[i]));
        step(1'b0, 4'h0);
        checks++; if (bus.code_ack !== 1'b1 || bus.code !== 16'h8642) begin errors++; $display("FAIL abort_pre: got %b/%h want 1/8642", bus.code_ack, bus.code); end
        vehicle_left = 1'b1;
        step(1'b0, 4'h0);
        checks++; if (bus.code_ack !== 1'b0 || bus.code !== '0 || bus.entry_active !== 1'b0) begin errors++; $display("FAIL abort_mid_ack: got %b/%h/%b want 0/0/0", bus.code_ack, bus.code, bus.entry_active); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'(i + 1));
            checks++; if (bus.key_reject !== 1'b0 || bus.digit_count !== '0 || bus.entry_active !== 1'b0) begin errors++; $display("FAIL idle_keys%0d: got %b/%0d/%b want 0/0/0", i, bus.key_reject, bus.digit_count, bus.entry_active); end
        end
        vehicle_left = 1'b0;
        step(1'b1, 4'h5);
        checks++; if (bus.entry_active !== 1'b1 || bus.digit_count !== '0 || bus.key_reject !== 1'b0) begin errors++; $display("FAIL arrival_key_ignored: got %b/%0d/%b want 1/0/0", bus.entry_active, bus.digit_count, bus.key_reject); end
    endtask

    task automatic test_held_key();
        logic rej = 1'b0;
        logic [2:0] exp4 = EDGE ? 3'd1 : 3'd4;
        logic [2:0] exp_again = EDGE ? 3'd2 : 3'd4;
        logic       exp_rej5 = !EDGE;
        do_reset();
        vehicle_arrival = 1'b1;
        step(1'b0, 4'h0);
        repeat (4) begin step(1'b1, 4'h7); rej |= bus.key_reject; end
        checks++; if (bus.digit_count !== exp4 || rej !== 1'b0) begin errors++; $display("FAIL held4: got cnt %0d rej %b want %0d/0", bus.digit_count, rej, exp4); end
        step(1'b1, 4'h7);
        checks++; if (bus.digit_count !== exp4 || bus.key_reject !== exp_rej5) begin errors++; $display("FAIL held5: got cnt %0d rej %b want %0d/%b", bus.digit_count, bus.key_reject, exp4, exp_rej5); end
        step(1'b0, 4'h0);
        step(1'b1, 4'h7);
        checks++; if (bus.digit_count !== exp_again) begin errors++; $display("FAIL repress: got %0d want %0d", bus.digit_count, exp_again); end
    endtask

    task automatic test_random();
        bit va, vl, kv;
        int kval, r, kv_pct;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            kv_pct = 10 + 20 * ((cyc / 150) % 4);
            va = ($urandom_range(0, 99) < 97);
            vl = ($urandom_range(0, 99) < 2);
            kv = ($urandom_range(0, 99) < kv_pct);
            r  = $urandom_range(0, 99);
            if (r < 65)      kval = $urandom_range(0, 9);
            else if (r < 75) kval = 10;
            else if (r < 92) kval = 11;
            else             kval = $urandom_range(12, 15);
            vehicle_arrival = va;
            vehicle_left = vl;
            model_step(va, vl, kv, kval);
            step(kv, 4'(kval));
            checks++; if (bus.code !== m_code[CW-1:0]) begin errors++; $display("FAIL rnd_code@%0d: got %h want %h", cyc, bus.code, m_code[CW-1:0]); end
            checks++; if (bus.code_ack !== (m_ack_left > 0)) begin errors++; $display("FAIL rnd_ack@%0d: got %b want %b", cyc, bus.code_ack, m_ack_left > 0); end
            checks++; if (bus.entry_active !== m_active) begin errors++; $display("FAIL rnd_active@%0d: got %b want %b", cyc, bus.entry_active, m_active); end
            checks++; if (int'(bus.digit_count) !== m_q.size()) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, bus.digit_count, m_q.size()); end
            checks++; if (bus.key_reject !== m_reject) begin errors++; $display("FAIL rnd_reject@%0d: got %b want %b", cyc, bus.key_reject, m_reject); end
        end
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_value = 4'h0;
        test_reset();
        test_normal_entry();
        test_short_invalid();
        test_clear_timeout();
        test_abort();
        test_held_key();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_code_entry.md
Name: keypad_code_entry

Overview:
- Upstream stage of the parking controller. Collects BCD digits from the entry-gate keypad while a vehicle is present.
- Assembles the digits into the packed PIN word `code` and strobes `code_ack` to hand the attempt to the controller.
- Handles digit shifting, clear/enter keys, an inter-key timeout, and session abort when the vehicle leaves.
- Attempt counting and alarm policy stay downstream in the controller.

Parameters:
- NUM_DIGITS, 4: digits per PIN. `code` width is 4*NUM_DIGITS.
- ACK_CYCLES, 4: number of cycles `code_ack` is held high per submission (≥1).
- TIMEOUT_CYCLES, 1000: idle cycles between keys before the partial entry is discarded (≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- vehicle_arrival  in  1  vehicle present at gate, level.
- vehicle_left  in  1  vehicle has cleared the gate, level.
- key_valid  in  1  key strobe; one key per high cycle.
- key_value  in  4  key code: 0-9 digit, 4'hA clear, 4'hB enter, 4'hC-4'hF invalid.
- code  out  4*NUM_DIGITS  submitted PIN, packed BCD; first digit in the most significant nibble.
- code_ack  out  1  submission strobe to the controller.
- entry_active  out  1  high in COLLECT and ACK.
- digit_count  out  $clog2(NUM_DIGITS+1)  digits currently buffered.
- key_reject  out  1  one-cycle pulse when a key is discarded.

Behaviour:
- Reset (rst=0, async): state IDLE, code=0, code_ack=0, entry_active=0, digit_count=0, key_reject=0, internal buffer=0, timeout counter=0.
- Abort condition: vehicle_left=1 or vehicle_arrival=0.
  - Applies in any state and has highest priority.
  - Next state IDLE; code, buffer and digit_count cleared; code_ack deasserted the same edge, including mid-ACK.
- IDLE:
  - Keys ignored, with no key_reject.
  - vehicle_arrival=1 and vehicle_left=0 → COLLECT with buffer cleared.
  - A key presented in that transition cycle is ignored.
- COLLECT, on an accepted digit (0-9):
  - With digit_count<NUM_DIGITS: buffer = {buffer[4*NUM_DIGITS-5:0], key_value}, digit_count+1.
  - With the buffer full: digit dropped, key_reject pulses, buffer unchanged.
- COLLECT, clear (4'hA): buffer=0, digit_count=0, no reject.
- COLLECT, enter (4'hB):
  - With digit_count==NUM_DIGITS: code←buffer, buffer/digit_count cleared, → ACK.
  - With a short entry: key_reject pulses, buffer and digit_count cleared, stay COLLECT.
- COLLECT, invalid key (4'hC-4'hF): key_reject pulses, buffer unchanged.
- Timeout:
  - The counter reloads on every key_valid and counts only in COLLECT while digit_count>0.
  - On reaching TIMEOUT_CYCLES: buffer and digit_count cleared, key_reject pulses once, stay COLLECT.
- Enter latency: enter sampled at edge N → code valid and code_ack=1 from edge N.
  - code_ack holds for exactly ACK_CYCLES cycles, then → COLLECT.
- ACK:
  - code held stable the whole time.
  - Any key_valid is discarded with a key_reject pulse.
- After ACK, code holds the last submission until the next enter or an abort.
- key_reject is registered and asserted the cycle after the offending key is sampled.
- entry_active is high in COLLECT and ACK only.

Optional Feature:
- Macro: KEY_EDGE_DETECT_EN.
- Defined:
  - key_valid is registered internally.
  - A key is accepted only on a 0→1 transition (key_valid & ~key_valid_q), so a held key counts once.
  - key_valid_q resets to 0, which means a key held high through reset release counts once.
  - No added latency.
- Undefined: every cycle key_valid=1 is a separate key press.

Test Plan:
- Reset/values: rst=0 mid-COLLECT with 2 digits buffered → all outputs 0 immediately, without waiting for a clock edge.
- Normal entry: arrival=1, keys 5,9,9,0,B one per cycle → code=16'h5990, code_ack high 4 cycles, digit_count back to 0, no key_reject.
- Short entry and invalid keys: keys 1,2,B → key_reject pulse, code stays 0. Then key E → key_reject, digit_count unchanged. Then keys 1,2,3,4,5 → 5th digit rejected, then B → code=16'h1234.
- Clear and timeout: keys 3,1,A → digit_count=0. Keys 3,1 then idle TIMEOUT_CYCLES → buffer cleared, single key_reject. Then 4,3,2,1,B → code=16'h4321.
- Abort: vehicle_left=1 during the 2nd ACK cycle → code_ack=0 and code=0 next edge, state IDLE. Keys in IDLE cause no response.
- Edge detect: with KEY_EDGE_DETECT_EN, key_valid held 5 cycles with value 7 → digit_count=1. Without the macro → digit_count=4 and key_reject on the 5th cycle.
